fpu_fp16_to_int: RTL and testbench

- Iterative converter: accepts an fp16_t operand and returns a 16-bit integer (signed or unsigned per request), rounded round-to-nearest-even.
- Saturates on overflow and reports opStatusFlag_t {OF, UF, NX}.
- It is the decode direction of the FPU normalizer/packer, which builds fp16 from sign/exp/significand. This block takes fp16 apart back into fixed point.
- Sits on the FPU result path behind a valid/ready handshake; one shift per cycle keeps the shifter single-bit.

---
 rtl/fpu_fp16_to_int_pkg.sv | 39 +++
 rtl/fpu_int_round_sat.sv | 72 +++++++
 rtl/fpu_fp16_to_int.sv | 162 ++++++++++++++++
 tb/tb_fpu_fp16_to_int.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_fp16_to_int_pkg.sv
// Shared types and constants for the fp16 -> integer converter.
// Holds the operand/flag layouts, FSM states and special-value helper.
package fpu_fp16_to_int_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
    } opStatusFlag_t;

    localparam int FP16_BIAS = 15;
    localparam int FP16_SIGW = 11;
    localparam int MAGW      = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } convState_t;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } specClass_t;

    function automatic logic fpuIsSpecialValue(input fp16_t v);
        return v.exp == 5'h1f;
    endfunction

endpackage

// File: rtl/fpu_int_round_sat.sv
// Round-to-nearest-even, sign application and saturation of a
// fixed-point magnitude into an INTW-bit signed/unsigned integer.
module fpu_int_round_sat
    import fpu_fp16_to_int_pkg::*;
#(
    parameter int INTW = 16
) (
    input  logic [MAGW-1:0] magnitude,
    input  logic            guard,
    input  logic            sticky,
    input  logic            sign,
    input  logic            signedMode,
    input  logic [1:0]      specClass,
    output logic [INTW-1:0] intOut,
    output logic [2:0]      flags
);

    localparam int RW = 34;
    localparam logic [INTW-1:0] UMAX = {INTW{1'b1}};
    localparam logic [INTW-1:0] SMAX = {1'b0, {(INTW-1){1'b1}}};
    localparam logic [INTW-1:0] SMIN = {1'b1, {(INTW-1){1'b0}}};

    specClass_t    cls;
    logic          round_up;
    logic [RW-1:0] rmag;
    logic          of;

    assign cls = specClass_t'(specClass);

    // Round, then pick the result and overflow status by input class and mode.
    always_comb begin
        round_up = guard & (sticky | magnitude[0]);
        rmag     = RW'(magnitude) + RW'(round_up);
        intOut   = '0;
        of       = 1'b0;
        if (cls == CLS_ZERO) begin
            intOut = '0;
        end else if (cls == CLS_NAN || (cls == CLS_INF && !sign)) begin
            intOut = signedMode ? SMAX : UMAX;
            of     = 1'b1;
        end else if (cls == CLS_INF) begin
            intOut = signedMode ? SMIN : '0;
            of     = 1'b1;
        end else if (!signedMode && sign) begin
            intOut = '0;
            of     = (rmag != '0);
        end else if (!signedMode) begin
            if (rmag > RW'(UMAX)) begin
                intOut = UMAX;
                of     = 1'b1;
            end else begin
                intOut = rmag[INTW-1:0];
            end
        end else if (!sign) begin
            if (rmag > RW'(SMAX)) begin
                intOut = SMAX;
                of     = 1'b1;
            end else begin
                intOut = rmag[INTW-1:0];
            end
        end else begin
            if (rmag > RW'(SMIN)) begin
                intOut = SMIN;
                of     = 1'b1;
            end else begin
                intOut = -rmag[INTW-1:0];
            end
        end
        flags = {of, 1'b0, (guard | sticky) & ~of};
    end

endmodule

// File: rtl/fpu_fp16_to_int.sv
// Iterative fp16 -> integer converter, one significand shift per cycle,
// round-to-nearest-even with saturation, behind valid/ready handshakes.
module fpu_fp16_to_int
    import fpu_fp16_to_int_pkg::*;
#(
    parameter int INTW       = 16,
    parameter int RSHIFT_CAP = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    output logic            inReady,
    input  logic [15:0]     fpuIn,
    input  logic            signedMode,
    output logic            outValid,
    input  logic            outReady,
    output logic [INTW-1:0] intOut,
    output logic [2:0]      opStatusFlags
);

    // Biased exponent at which the significand is already an integer.
    localparam int EXP_INT = FP16_BIAS + FP16_SIGW - 1;

    convState_t state, state_nxt;

    fp16_t                op;
    logic [4:0]           exp_eff;
    logic [4:0]           rdist;
    logic [3:0]           shift_n;
    logic                 shift_left;
    specClass_t           in_cls;
    logic [FP16_SIGW-1:0] in_sig;

    logic [MAGW-1:0] mag;
    logic            grd;
    logic            stk;
    logic            sgn;
    logic            smode;
    specClass_t      cls;
    logic [3:0]      cnt;
    logic            left;

    logic [INTW-1:0] rs_int;
    logic [2:0]      rs_flags;

    assign op       = fp16_t'(fpuIn);
    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);

    // Classify the incoming operand and work out shift direction and count.
    always_comb begin
        exp_eff    = (op.exp == 5'd0) ? 5'd1 : op.exp;
        in_sig     = {op.exp != 5'd0, op.frac};
        rdist      = 5'(EXP_INT) - exp_eff;
        shift_left = (exp_eff >= 5'(EXP_INT));
        shift_n    = '0;
        in_cls     = CLS_NORM;
        if (fpuIsSpecialValue(op)) begin
            in_cls = (op.frac != 10'd0) ? CLS_NAN : CLS_INF;
        end else if (op.exp == 5'd0 && op.frac == 10'd0) begin
            in_cls = CLS_ZERO;
        end else if (shift_left) begin
            shift_n = 4'(exp_eff - 5'(EXP_INT));
        end else if (rdist > 5'(RSHIFT_CAP)) begin
            shift_n = 4'(RSHIFT_CAP);
        end else begin
            shift_n = rdist[3:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (inValid) begin
                    state_nxt = (shift_n != 4'd0) ? SHIFT : ROUND;
                end
            end
            SHIFT: begin
                if (cnt == 4'd1) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: state_nxt = DONE;
            DONE: begin
                if (outReady) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Operand capture, single-bit shifting and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag           <= '0;
            grd           <= 1'b0;
            stk           <= 1'b0;
            sgn           <= 1'b0;
            smode         <= 1'b0;
            cls           <= CLS_ZERO;
            cnt           <= '0;
            left          <= 1'b0;
            intOut        <= '0;
            opStatusFlags <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inValid) begin
                        mag   <= MAGW'(in_sig);
                        grd   <= 1'b0;
                        stk   <= 1'b0;
                        sgn   <= op.sign;
                        smode <= signedMode;
                        cls   <= in_cls;
                        cnt   <= shift_n;
                        left  <= shift_left;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 4'd1;
                    if (left) begin
                        mag <= mag << 1;
                    end else begin
                        mag <= mag >> 1;
                        grd <= mag[0];
                        stk <= stk | grd;
                    end
                end
                ROUND: begin
                    intOut        <= rs_int;
                    opStatusFlags <= rs_flags;
                end
                DONE: ;
            endcase
        end
    end

    fpu_int_round_sat #(
        .INTW(INTW)
    ) u_round_sat (
        .magnitude (mag),
        .guard     (grd),
        .sticky    (stk),
        .sign      (sgn),
        .signedMode(smode),
        .specClass (cls),
        .intOut    (rs_int),
        .flags     (rs_flags)
    );

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Bench for fpu_fp16_to_int: directed and random operands, a queue-based
// scoreboard, an arithmetic reference model and handshake/reset checks.
module tb_fpu_fp16_to_int;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [15:0] fpuIn;
    logic        signedMode;
    logic        outValid;
    logic        outReady;
    logic [15:0] intOut;
    logic [2:0]  opStatusFlags;

    fpu_fp16_to_int #(
        .INTW(16),
        .RSHIFT_CAP(12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inValid      (inValid),
        .inReady      (inReady),
        .fpuIn        (fpuIn),
        .signedMode   (signedMode),
        .outValid     (outValid),
        .outReady     (outReady),
        .intOut       (intOut),
        .opStatusFlags(opStatusFlags)
    );

    typedef struct {
        logic [15:0] v;
        logic [2:0]  f;
        int          lat;
        time         t_acc;
    } exp_t;

    typedef struct {
        logic [15:0] op;
        logic        sm;
        logic [15:0] v;
        logic [2:0]  f;
        int          lat;
    } dir_t;

    exp_t sb[$];
    dir_t dq[$];

    int total = 0;
    int bad   = 0;
    bit hold  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Value of fp16 scaled by 2^24 is an exact integer; round that to nearest-even.
    function automatic exp_t ref_model(input logic [15:0] op, input logic sm);
        exp_t   r;
        int     ex, fr, e, n;
        longint sig, scaled, q, rem, half, val;
        bit     up, inx, of;
        ex = int'(op[14:10]);
        fr = int'(op[9:0]);
        r.t_acc = 0;
        if (ex == 31) begin
            r.lat = 2;
            r.f   = 3'b100;
            if (fr != 0 || !op[15]) r.v = sm ? 16'h7fff : 16'hffff;
            else                    r.v = sm ? 16'h8000 : 16'h0000;
            return r;
        end
        if (ex == 0 && fr == 0) begin
            r.v = 0; r.f = 0; r.lat = 2;
            return r;
        end
        sig = (ex != 0) ? longint'(1024 + fr) : longint'(fr);
        e   = ((ex == 0) ? 1 : ex) - 15;
        if (e >= 10) n = e - 10;
        else         n = ((10 - e) > 12) ? 12 : (10 - e);
        r.lat  = n + 2;
        scaled = sig << (e + 14);
        half   = 64'h1 << 23;
        q      = scaled >> 24;
        rem    = scaled - (q << 24);
        inx    = (rem != 0);
        up     = (rem > half) || (rem == half && (q % 2) == 1);
        val    = q + longint'(up);
        if (op[15]) val = -val;
        of = 0;
        if (sm) begin
            if (val > 32767)       begin r.v = 16'h7fff; of = 1; end
            else if (val < -32768) begin r.v = 16'h8000; of = 1; end
            else                   r.v = 16'(val);
        end else begin
            if (val < 0)          begin r.v = 16'h0000; of = 1; end
            else if (val > 65535) begin r.v = 16'hffff; of = 1; end
            else                  r.v = 16'(val);
        end
        r.f = {of, 1'b0, inx & !of};
        return r;
    endfunction

    task automatic send(input logic [15:0] op, input logic sm, input bit track, input exp_t e);
        int w = 0;
        @(negedge clk);
        while (!inReady && w < 300) begin
            inValid = 1'($urandom_range(0, 1));
            fpuIn   = 16'($urandom);
            @(negedge clk);
            w++;
        end
        if (!inReady) begin
            total++; bad++;
            $display("FAIL send_timeout: got inReady=0 want 1");
            inValid = 1'b0;
            return;
        end
        inValid    = 1'b1;
        fpuIn      = op;
        signedMode = sm;
        @(posedge clk);
        e.t_acc = $time;
        if (track) sb.push_back(e);
        #1;
        inValid    = 1'b0;
        fpuIn      = 16'($urandom);
        signedMode = 1'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic add_dir(input logic [15:0] op, input logic sm, input logic [15:0] v,
                           input logic [2:0] f, input int lat);
        dir_t d;
        d.op = op; d.sm = sm; d.v = v; d.f = f; d.lat = lat;
        dq.push_back(d);
    endtask

    // Consumer readiness: random back-pressure unless a hold is requested.
    initial begin
        outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            outReady = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop and compare on each new result, then check it stays stable.
    exp_t        it;
    bit          rep = 0;
    bit          ack_prev = 0;
    logic [15:0] hv;
    logic [2:0]  hf;
    int          lat_meas;
    always @(negedge clk) begin
        if (rst) begin
            rep      = 0;
            ack_prev = 0;
        end else begin
            if (ack_prev) chk("inready_after_ack", 32'(inReady), 32'd1);
            ack_prev = 0;
            if (outValid) begin
                chk("inready_in_done", 32'(inReady), 32'd0);
                if (!rep) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output: got %h want none", intOut);
                    end else begin
                        it = sb.pop_front();
                        lat_meas = int'(($time - it.t_acc - 5) / 10) + 1;
                        chk("value", 32'(intOut), 32'(it.v));
                        chk("flags", 32'(opStatusFlags), 32'(it.f));
                        chk("latency", 32'(lat_meas), 32'(it.lat));
                    end
                    hv  = intOut;
                    hf  = opStatusFlags;
                    rep = 1;
                end else begin
                    chk("hold_value", 32'(intOut), 32'(hv));
                    chk("hold_flags", 32'(opStatusFlags), 32'(hf));
                end
                if (outReady) begin
                    ack_prev = 1;
                    rep      = 0;
                end
            end
        end
    end

    initial begin
        exp_t        e;
        logic [15:0] op;
        logic        sm;
        int          w;
        rst        = 1'b1;
        inValid    = 1'b0;
        fpuIn      = 16'h0;
        signedMode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inready", 32'(inReady), 32'd1);
        chk("rst_outvalid", 32'(outValid), 32'd0);
        chk("rst_intout", 32'(intOut), 32'd0);
        chk("rst_flags", 32'(opStatusFlags), 32'd0);
        rst = 1'b0;

        add_dir(16'h3E00, 1, 16'h0002, 3'b001, 12);
        add_dir(16'h4100, 1, 16'h0002, 3'b001, 11);
        add_dir(16'h7BFF, 0, 16'hFFE0, 3'b000, 7);
        add_dir(16'h7BFF, 1, 16'h7FFF, 3'b100, 7);
        add_dir(16'hC500, 1, 16'hFFFB, 3'b000, 10);
        add_dir(16'hC500, 0, 16'h0000, 3'b100, 10);
        add_dir(16'hB800, 0, 16'h0000, 3'b001, 13);
        add_dir(16'h0001, 1, 16'h0000, 3'b001, 14);
        add_dir(16'h7E00, 1, 16'h7FFF, 3'b100, 2);
        add_dir(16'hFC00, 1, 16'h8000, 3'b100, 2);
        add_dir(16'h8000, 0, 16'h0000, 3'b000, 2);
        foreach (dq[i]) begin
            e.v = dq[i].v; e.f = dq[i].f; e.lat = dq[i].lat; e.t_acc = 0;
            send(dq[i].op, dq[i].sm, 1, e);
        end

        drain();
        hold = 1;
        e.v = 16'h0002; e.f = 3'b001; e.lat = 11; e.t_acc = 0;
        send(16'h4100, 1, 1, e);
        w = 0;
        while (!outValid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("hold_reached_done", 32'(outValid), 32'd1);
        repeat (5) @(negedge clk);
        hold = 0;

        for (int k = 0; k < 200; k++) begin
            op = 16'($urandom);
            sm = 1'($urandom);
            send(op, sm, 1, ref_model(op, sm));
        end
        drain();

        e = ref_model(16'h3E00, 1);
        send(16'h3E00, 1, 0, e);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_outvalid", 32'(outValid), 32'd0);
        chk("midrst_inready", 32'(inReady), 32'd1);
        repeat (25) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
